line_steer_ctrl: RTL and testbench

Upstream steering controller for the line follower. Synchronises the 8-channel IR line-sensor array, samples it at a fixed rate and computes a signed line-position error. A PD law turns that error into the 8-bit `servo` steering command that the differential-drive PWM stage consumes. Also detects and handles loss of the line.

---
 rtl/line_steer_ctrl_pkg.sv | 31 +++
 rtl/line_steer_ctrl_if.sv | 25 ++
 rtl/line_steer_ctrl_tick_gen.sv | 30 +++
 rtl/line_steer_ctrl.sv | 169 ++++++++++++++++
 tb/tb_line_steer_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/line_steer_ctrl_pkg.sv
// steer_pkg: shared definitions for the line-follower steering controller.
//   SERVO_CENTER / SERVO_MIN / SERVO_MAX : servo command endpoints
//   w(i)           : signed weight of sensor bit i (2i-7, i.e. -7..+7)
//   steer_state_t  : controller FSM states
//   side_t         : side of the array the line was last seen on
package steer_pkg;

  localparam logic [7:0] SERVO_CENTER = 8'd128;
  localparam logic [7:0] SERVO_MIN    = 8'd0;
  localparam logic [7:0] SERVO_MAX    = 8'd255;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_OUTPUT  = 2'd3
  } steer_state_t;

  // CENTRE is encoded as zero so that the reset value is all-zeroes.
  typedef enum logic [1:0] {
    CENTRE = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2
  } side_t;

  // Bit 0 is the leftmost sensor (-7), bit 7 the rightmost (+7).
  function automatic logic signed [5:0] w(input int i);
    return 6'(2 * i - 7);
  endfunction

endpackage

// File: rtl/line_steer_ctrl_if.sv
// line_steer_ctrl_if: sensor input and steering output bundle.
//   sensors     : raw IR array (asynchronous), 1 = line seen, bit 0 = leftmost
//   servo       : steering command, 0 = hard left, 128 = straight, 255 = hard right
//   servo_valid : one-cycle pulse in the cycle servo takes a new value
//   line_lost   : high while the line has been missing for the timeout
//   state       : controller FSM state, exported for observation
// Handshake: servo_valid is a strobe with no ready. The consumer cannot stall
// the controller; servo holds its value between strobes, so a consumer may
// either latch on servo_valid or simply use servo continuously.
// modport master: the steering controller. modport slave: the consumer
// (PWM stage) that also owns the sensor wiring.
interface line_steer_ctrl_if;
  import steer_pkg::*;

  logic [7:0]   sensors;
  logic [7:0]   servo;
  logic         servo_valid;
  logic         line_lost;
  steer_state_t state;

  modport master (input sensors, output servo, output servo_valid,
                  output line_lost, output state);
  modport slave  (output sensors, input servo, input servo_valid,
                  input line_lost, input state);
endinterface

// File: rtl/line_steer_ctrl_tick_gen.sv
// tick_gen: free-running prescaler producing a registered one-cycle tick
// every DIV clocks. The first tick after reset appears DIV cycles after rst
// deasserts.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   tick : one-cycle pulse, period DIV
module tick_gen #(
  parameter int unsigned DIV = 8
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/line_steer_ctrl.sv
// line_steer_ctrl: line-follower steering controller.
// Synchronises the 8-channel IR array, samples it every CLK_HZ/SAMPLE_HZ
// clocks, forms a weighted line-position error and applies a PD law to
// produce the servo command. When the line disappears it steers toward the
// side it was last seen on, and after LOST_TIMEOUT empty samples raises
// line_lost and straightens the servo.
// Build option: STEER_DERIV_EN defined builds the derivative term (e_prev
// register, subtractor, KD product); undefined gives a P-only law.
//   clk : system clock        rst : synchronous active-high reset
//   bus : line_steer_ctrl_if.master (sensors in; servo, servo_valid,
//         line_lost, state out)
module line_steer_ctrl
  import steer_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SAMPLE_HZ    = 1000,
  parameter int unsigned KP           = 4,
  parameter int unsigned KD           = 2,
  parameter int unsigned LOST_TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  line_steer_ctrl_if.master     bus
);
  localparam int unsigned DIV = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned LW  = $clog2(LOST_TIMEOUT + 1);
  localparam logic signed [11:0] KP_S = 12'(KP);

  // The FSM needs the whole WAIT->OUTPUT sequence to finish before the next
  // tick, and gains are 4-bit.
  if (DIV < 8 || KP > 15 || KD > 15 || LOST_TIMEOUT < 1) begin : g_param_check
    $error("line_steer_ctrl: illegal parameter set");
  end

  logic [7:0]         sync1, sync2, s;
  logic               tick;
  steer_state_t       state, state_nxt;
  side_t              last_side, side_nxt;
  logic [LW-1:0]      lost_cnt, lost_nxt;
  logic signed [5:0]  e;
  logic signed [11:0] u;
  logic signed [12:0] servo_raw;
  logic [7:0]         pd_servo, servo_nxt;
  logic [7:0]         servo_q;
  logic               servo_valid_q, line_lost_q, lost_flag_nxt;
  logic               line_present;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.sensors;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT:    if (tick) state_nxt = ST_SAMPLE;
      ST_SAMPLE:  state_nxt = ST_COMPUTE;
      ST_COMPUTE: state_nxt = ST_OUTPUT;
      ST_OUTPUT:  state_nxt = ST_WAIT;
      default:    state_nxt = ST_WAIT;
    endcase
  end

  // Weighted sum only; no normalisation by the number of active sensors.
  always_comb begin
    e = '0;
    for (int i = 0; i < 8; i++) begin
      if (s[i]) e = e + w(i);
    end
  end

`ifdef STEER_DERIV_EN
  localparam logic signed [11:0] KD_S = 12'(KD);
  logic signed [5:0] e_prev;
  logic signed [6:0] d;

  assign d = $signed({e[5], e}) - $signed({e_prev[5], e_prev});
  assign u = KP_S * $signed({{6{e[5]}}, e}) + KD_S * $signed({{5{d[6]}}, d});

  // e_prev is frozen while the line is absent so recovery differentiates
  // against the last real position.
  always_ff @(posedge clk) begin
    if (rst)                                      e_prev <= '0;
    else if (state == ST_COMPUTE && line_present) e_prev <= e;
  end
`else
  assign u = KP_S * $signed({{6{e[5]}}, e});
`endif

  assign servo_raw = $signed({5'd0, SERVO_CENTER}) + $signed({u[11], u});

  always_comb begin
    if (servo_raw < 13'sd0)        pd_servo = SERVO_MIN;
    else if (servo_raw > 13'sd255) pd_servo = SERVO_MAX;
    else                           pd_servo = servo_raw[7:0];
  end

  assign line_present = (s != 8'd0);

  always_comb begin
    lost_nxt      = lost_cnt;
    side_nxt      = last_side;
    servo_nxt     = pd_servo;
    lost_flag_nxt = 1'b0;
    if (line_present) begin
      lost_nxt = '0;
      if (e > 6'sd0)      side_nxt = RIGHT;
      else if (e < 6'sd0) side_nxt = LEFT;
      else                side_nxt = CENTRE;
    end else begin
      if (lost_cnt != LW'(LOST_TIMEOUT)) lost_nxt = lost_cnt + LW'(1);
      if (lost_nxt == LW'(LOST_TIMEOUT)) begin
        lost_flag_nxt = 1'b1;
        servo_nxt     = SERVO_CENTER;
      end else begin
        case (last_side)
          LEFT:    servo_nxt = SERVO_MIN;
          RIGHT:   servo_nxt = SERVO_MAX;
          default: servo_nxt = SERVO_CENTER;
        endcase
      end
    end
  end

  // Results are registered at the end of COMPUTE so servo, servo_valid and
  // line_lost all change together in the OUTPUT cycle, three cycles after tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      s             <= '0;
      servo_q       <= SERVO_CENTER;
      servo_valid_q <= 1'b0;
      line_lost_q   <= 1'b0;
      lost_cnt      <= '0;
      last_side     <= CENTRE;
    end else begin
      servo_valid_q <= 1'b0;
      if (state == ST_SAMPLE) s <= sync2;
      if (state == ST_COMPUTE) begin
        servo_q       <= servo_nxt;
        servo_valid_q <= 1'b1;
        line_lost_q   <= lost_flag_nxt;
        lost_cnt      <= lost_nxt;
        last_side     <= side_nxt;
      end
    end
  end

  assign bus.servo       = servo_q;
  assign bus.servo_valid = servo_valid_q;
  assign bus.line_lost   = line_lost_q;
  assign bus.state       = state;

endmodule

// File: tb/tb_line_steer_ctrl.sv
// tb_line_steer_ctrl: directed vectors with hand-computed servo/line_lost
// values for line_steer_ctrl, run at a 16-clock sample period. Expected
// values cover both builds (with and without STEER_DERIV_EN).
module tb_line_steer_ctrl;
  import steer_pkg::*;

  localparam int DIV     = 16;
  localparam int LOST_TO = 200;
  localparam int BUDGET  = 3 * DIV;

`ifdef STEER_DERIV_EN
  localparam bit DERIV = 1'b1;
`else
  localparam bit DERIV = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_steer_ctrl_if bus ();

  line_steer_ctrl #(
    .CLK_HZ       (DIV),
    .SAMPLE_HZ    (1),
    .KP           (4),
    .KD           (2),
    .LOST_TIMEOUT (LOST_TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pick(input int pd, input int p);
    return DERIV ? 8'(pd) : 8'(p);
  endfunction

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  string      tag_q[$];
  logic [8:0] mon_exp;
  string      mon_tag;

  always @(negedge clk) begin
    if (!rst && bus.servo_valid === 1'b1) begin
      check("valid_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        check({mon_tag, "_servo"}, bus.servo, mon_exp[7:0]);
        check({mon_tag, "_lost"}, bus.line_lost, mon_exp[8]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic expect_result(input logic [7:0] servo, input logic lost, input string tag);
    exp_q.push_back({lost, servo});
    tag_q.push_back(tag);
  endtask

  task automatic sample(input logic [7:0] sens, input logic [7:0] servo,
                        input logic lost, input string tag);
    int b;
    bus.sensors = sens;
    expect_result(servo, lost, tag);
    b = 0;
    @(negedge clk);
    while (bus.servo_valid !== 1'b1 && b < BUDGET) begin
      @(negedge clk);
      b++;
    end
    check({tag, "_timeout"}, 32'(b < BUDGET), 1);
    @(negedge clk);
  endtask

  // Counts negedges from reset release to the first servo_valid.
  task automatic measure_latency(input string tag);
    int cyc;
    cyc = 0;
    while (bus.servo_valid !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, cyc, DIV + 3);
    @(negedge clk);
    check({tag, "_pulse_once"}, bus.servo_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int b;
    bus.sensors = 8'b0001_1000;
    repeat (3) @(negedge clk);
    check("rst_servo", bus.servo, 128);
    check("rst_valid", bus.servo_valid, 0);
    check("rst_lost", bus.line_lost, 0);
    check("rst_state", bus.state, ST_WAIT);

    // First sample: centred line, servo straight, 3 cycles after the tick.
    expect_result(8'd128, 1'b0, "centre_first");
    rst = 1'b0;
    measure_latency("first_latency");

    sample(8'b1000_0000, pick(170, 156), 1'b0, "pos7_first");
    repeat (4) @(negedge clk);
    check("hold_servo", bus.servo, pick(170, 156));
    check("hold_valid", bus.servo_valid, 0);
    sample(8'b1000_0000, 8'd156,         1'b0, "pos7_repeat");
    sample(8'b0000_1111, pick(18, 64),   1'b0, "neg16_first");
    sample(8'b0000_1111, 8'd64,          1'b0, "neg16_repeat");
    sample(8'b1111_0000, pick(255, 192), 1'b0, "clamp_high");
    sample(8'b0000_1111, pick(0, 64),    1'b0, "clamp_low");
    sample(8'b1000_0000, pick(202, 156), 1'b0, "pos7_from_neg16");
    sample(8'b1000_0000, 8'd156,         1'b0, "pos7_settle");

    // Reset during COMPUTE: the sample is dropped and e_prev returns to 0.
    bus.sensors = 8'b1000_0000;
    b = 0;
    while (bus.state !== ST_COMPUTE && b < BUDGET) begin
      @(negedge clk);
      b++;
    end
    check("reach_compute", 32'(b < BUDGET), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_servo", bus.servo, 128);
    check("midrst_valid", bus.servo_valid, 0);
    check("midrst_state", bus.state, ST_WAIT);
    rst = 1'b0;
    expect_result(pick(170, 156), 1'b0, "after_rst");
    measure_latency("rst_latency");

    sample(8'b1000_0000, 8'd156, 1'b0, "pos7_rearm");

    // Line lost after being seen on the right.
    for (int k = 1; k <= LOST_TO + 1; k++) begin
      if (k < LOST_TO) sample(8'd0, 8'd255, 1'b0, $sformatf("empty%0d", k));
      else             sample(8'd0, 8'd128, 1'b1, $sformatf("empty%0d", k));
    end

    sample(8'b0001_1000, pick(114, 128), 1'b0, "recover");
    sample(8'b0000_0001, pick(86, 100),  1'b0, "left7");
    sample(8'b0000_0000, 8'd0,           1'b0, "search_left");
    sample(8'b0001_1000, pick(142, 128), 1'b0, "centre_from_left");
    sample(8'b0000_0000, 8'd128,         1'b0, "search_centre");
    sample(8'b0000_0110, pick(80, 96),   1'b0, "pair_left");

    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
